// File: rtl/sram6116_arbiter_pkg.sv
// Shared types and constants for the 6116 BRAM arbiter.
// Imported by the interface, the arbiter and its wait counter.
package sram6116_pkg;

   localparam int LANES      = 4;
   localparam int LANE_W     = 2;
   localparam int DEF_ADDR_W = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      B_RUN  = 2'd1,
      B_LAST = 2'd2,
      B_ACK  = 2'd3
   } state_e;

endpackage

// File: rtl/sram6116_arbiter_if.sv
// Bus bundle: Port A, Port B and the BRAM side of the arbiter.
// slave = arbiter view, master = requesters plus BRAM.
interface sram6116_arbiter_if
   import sram6116_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) ();

   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [7:0]        a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [7:0]        a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-3:0] b_addr;
   logic [31:0]       b_wdata;
   logic [3:0]        b_wstrb;
   logic              b_ack;
   logic [31:0]       b_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata, b_wstrb,
      output b_ack, b_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata, b_wstrb,
      input  b_ack, b_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/sram6116_arbiter_starve_cnt.sv
// Saturating count of IDLE cycles Port B has been denied.
// at_max_o lets B override Port A priority.
module sram6116_starve_cnt #(
   parameter int MAX_WAIT = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_max_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Clear wins over increment; hold once saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (inc_i && (cnt_q != 8'(MAX_WAIT))) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == 8'(MAX_WAIT));

endmodule

// File: rtl/sram6116_arbiter.sv
// Shares one 2Kx8 BRAM between an 8-bit port (A, priority)
// and a 32-bit word port (B) split into four byte cycles.
module sram6116_arbiter
   import sram6116_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MAX_WAIT = 8
) (
   input  logic              ACLK,
   input  logic              ARESET,
   sram6116_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [ADDR_W-3:0] b_addr_q;
   logic              b_we_q;
   logic [31:0]       b_wdata_q;
   logic [3:0]        b_wstrb_q;
   logic [31:0]       rdata_q;
   logic              cap_q;
   logic [LANE_W-1:0] cap_lane_q;
   logic              a_rv_q;

   logic b_start;
   logic a_serve;
   logic at_max;

   assign b_start = (state_q == IDLE) && bus.b_req
                    && (!bus.a_req || at_max);
   assign a_serve = (state_q == IDLE) && bus.a_req && !b_start;

   sram6116_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk_i    (ACLK),
      .rst_i    (ARESET),
      .clr_i    (b_start),
      .inc_i    (a_serve && bus.b_req),
      .at_max_o (at_max)
   );

   // State and lane registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= IDLE;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
      end
   end

   // Next state: B word runs four lanes then drains and acks.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      unique case (state_q)
         IDLE: begin
            if (b_start) begin
               state_d = B_RUN;
               lane_d  = '0;
            end
         end
         B_RUN: begin
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == LANE_W'(LANES - 1)) state_d = B_LAST;
         end
         B_LAST:  state_d = B_ACK;
         B_ACK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: A passes straight through in IDLE, B drives its lane.
   always_comb begin
      bus.a_gnt     = a_serve;
      bus.a_rvalid  = a_rv_q;
      bus.a_rdata   = a_rv_q ? bus.mem_rdata : 8'd0;
      bus.b_ack     = (state_q == B_ACK);
      bus.b_rdata   = rdata_q;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = 8'd0;
      if (a_serve) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.a_we;
         bus.mem_addr  = bus.a_addr;
         bus.mem_wdata = bus.a_wdata;
      end else if (state_q == B_RUN) begin
         bus.mem_addr = {b_addr_q, lane_q};
         if (b_we_q) begin
            bus.mem_en    = b_wstrb_q[lane_q];
            bus.mem_we    = b_wstrb_q[lane_q];
            bus.mem_wdata = b_wdata_q[{lane_q, 3'b000} +: 8];
         end else begin
            bus.mem_en = 1'b1;
         end
      end
   end

   // Latch the B request so the word stays stable for all lanes.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         b_addr_q  <= '0;
         b_we_q    <= 1'b0;
         b_wdata_q <= 32'd0;
         b_wstrb_q <= 4'd0;
      end else if (b_start) begin
         b_addr_q  <= bus.b_addr;
         b_we_q    <= bus.b_we;
         b_wdata_q <= bus.b_wdata;
         b_wstrb_q <= bus.b_wstrb;
      end
   end

   // Capture each B read byte one cycle after its lane issues.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cap_q      <= 1'b0;
         cap_lane_q <= '0;
         rdata_q    <= 32'd0;
      end else begin
         cap_q      <= (state_q == B_RUN) && !b_we_q;
         cap_lane_q <= lane_q;
         if (cap_q) rdata_q[{cap_lane_q, 3'b000} +: 8] <= bus.mem_rdata;
      end
   end

   // A read data is valid the cycle after its grant.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         a_rv_q <= 1'b0;
      end else begin
         a_rv_q <= a_serve && !bus.a_we;
      end
   end

endmodule

// File: tb/tb_sram6116_arbiter.sv
// Directed bench for sram6116_arbiter with a 2Kx8 BRAM model.
// Expected values are hand-computed constants.
module tb_sram6116_arbiter;
   import sram6116_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic proto_err = 1'b0;
   logic b_pend = 1'b0;
   logic [7:0] mem [0:2047];

   int         lat;
   logic [4:0] en;
   int         grants, gap, ackc, nextg, during;

   sram6116_arbiter_if #(.ADDR_W(11)) intf ();

   sram6116_arbiter #(
      .ADDR_W   (11),
      .MAX_WAIT (8)
   ) dut (
      .ACLK   (clk),
      .ARESET (rst),
      .bus    (intf)
   );

   always #5 clk = ~clk;

   // BRAM model: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (intf.mem_en) begin
         if (intf.mem_we) mem[intf.mem_addr] <= intf.mem_wdata;
         else intf.mem_rdata <= mem[intf.mem_addr];
      end
   end

   // b_req must stay high until b_ack.
   always @(negedge clk) begin
      if (rst) begin
         b_pend <= 1'b0;
      end else begin
         if (b_pend && !intf.b_req) proto_err <= 1'b1;
         if (intf.b_ack) b_pend <= 1'b0;
         else if (intf.b_req) b_pend <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles from now to b_ack; records mem_en for cycles 0..4.
   task automatic wait_ack(output int l, output logic [4:0] e);
      e = '0;
      l = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k <= 4) e[k] = intf.mem_en;
         l = k;
         if (intf.b_ack) break;
         tick();
      end
      tick();
      intf.b_req = 1'b0;
   endtask

   task automatic b_xact(input logic we, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output int l, output logic [4:0] e);
      intf.b_we    = we;
      intf.b_addr  = addr;
      intf.b_wdata = wd;
      intf.b_wstrb = st;
      intf.b_req   = 1'b1;
      wait_ack(l, e);
   endtask

   initial begin
      rst          = 1'b1;
      intf.a_req   = 1'b0;
      intf.a_we    = 1'b0;
      intf.a_addr  = '0;
      intf.a_wdata = '0;
      intf.b_req   = 1'b0;
      intf.b_we    = 1'b0;
      intf.b_addr  = '0;
      intf.b_wdata = '0;
      intf.b_wstrb = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_flags", {27'd0, intf.a_gnt, intf.a_rvalid, intf.b_ack,
                        intf.mem_en, intf.mem_we}, 32'd0);
      chk("rst_b_rdata", intf.b_rdata, 32'd0);
      chk("rst_a_rdata", {24'd0, intf.a_rdata}, 32'd0);
      chk("rst_mem_addr", {21'd0, intf.mem_addr}, 32'd0);
      rst = 1'b0;
      tick();

      // A write 0x5A to 0x123 then read it back.
      intf.a_req   = 1'b1;
      intf.a_we    = 1'b1;
      intf.a_addr  = 11'h123;
      intf.a_wdata = 8'h5A;
      @(negedge clk);
      chk("a_wr_gnt", {31'd0, intf.a_gnt}, 32'd1);
      chk("a_wr_mem", {intf.mem_en, intf.mem_we, intf.mem_addr,
                       intf.mem_wdata}, {2'b11, 11'h123, 8'h5A});
      tick();
      intf.a_we = 1'b0;
      @(negedge clk);
      chk("a_rd_gnt", {31'd0, intf.a_gnt}, 32'd1);
      chk("a_wr_no_rvalid", {31'd0, intf.a_rvalid}, 32'd0);
      tick();
      intf.a_req = 1'b0;
      @(negedge clk);
      chk("a_rd_rvalid", {31'd0, intf.a_rvalid}, 32'd1);
      chk("a_rd_data", {24'd0, intf.a_rdata}, 32'h5A);
      tick();

      // B full word write and readback.
      b_xact(1'b1, 9'h010, 32'hDEAD0011, 4'hF, lat, en);
      chk("b_wr_lat", lat, 6);
      chk("b_wr_en", {27'd0, en}, 32'h1E);
      chk("b_wr_bytes", {mem[11'h43], mem[11'h42], mem[11'h41],
                         mem[11'h40]}, 32'hDEAD0011);
      b_xact(1'b0, 9'h010, 32'h0, 4'h0, lat, en);
      chk("b_rd_lat", lat, 6);
      chk("b_rd_en", {27'd0, en}, 32'h1E);
      chk("b_rd_data", intf.b_rdata, 32'hDEAD0011);

      // Partial strobe over a preloaded word.
      b_xact(1'b1, 9'h010, 32'hBEEF0011, 4'hF, lat, en);
      b_xact(1'b1, 9'h010, 32'h12345678, 4'h5, lat, en);
      chk("b_part_en", {27'd0, en}, 32'h0A);
      chk("b_part_wr_data_kept", intf.b_rdata, 32'hDEAD0011);
      b_xact(1'b0, 9'h010, 32'h0, 4'h0, lat, en);
      chk("b_part_rd", intf.b_rdata, 32'hBE340078);

      // Starvation: A saturates, B must win after 8 grants.
      intf.a_req  = 1'b1;
      intf.a_we   = 1'b0;
      intf.a_addr = 11'h000;
      intf.b_we   = 1'b0;
      intf.b_addr = 9'h010;
      intf.b_req  = 1'b1;
      grants = 0;
      gap    = -1;
      ackc   = -1;
      nextg  = -1;
      during = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (gap < 0) begin
            if (intf.a_gnt) grants++;
            else gap = c;
         end else if (ackc < 0) begin
            if (intf.a_gnt) during++;
            if (intf.b_ack) ackc = c;
         end else if (intf.a_gnt) begin
            nextg = c;
            break;
         end
         tick();
         if (ackc >= 0) intf.b_req = 1'b0;
      end
      chk("starve_grants", grants, 8);
      chk("starve_accept", gap, 8);
      chk("starve_ack", ackc, 14);
      chk("starve_no_a_during_b", during, 0);
      chk("starve_next_a", nextg, 15);
      tick();
      intf.a_req = 1'b0;
      intf.b_req = 1'b0;
      tick();

      // Simultaneous start with an empty wait counter: A first.
      intf.a_req  = 1'b1;
      intf.a_we   = 1'b0;
      intf.a_addr = 11'h042;
      intf.b_we   = 1'b0;
      intf.b_addr = 9'h010;
      intf.b_req  = 1'b1;
      @(negedge clk);
      chk("sim_a_gnt", {31'd0, intf.a_gnt}, 32'd1);
      chk("sim_a_addr", {21'd0, intf.mem_addr}, 32'h042);
      tick();
      intf.a_req = 1'b0;
      wait_ack(lat, en);
      chk("sim_b_lat", lat, 6);
      chk("sim_b_en", {27'd0, en}, 32'h1E);

      // Reset in lane 2 of a write over a zeroed word.
      b_xact(1'b1, 9'h020, 32'h00000000, 4'hF, lat, en);
      intf.b_we    = 1'b1;
      intf.b_addr  = 9'h020;
      intf.b_wdata = 32'hA1B2C3D4;
      intf.b_wstrb = 4'hF;
      intf.b_req   = 1'b1;
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("rst_mid_lane2", {intf.mem_en, intf.mem_addr}, {1'b1, 11'h082});
      rst = 1'b1;
      #1;
      intf.b_req = 1'b0;
      chk("rst_mid_flags", {27'd0, intf.a_gnt, intf.a_rvalid, intf.b_ack,
                            intf.mem_en, intf.mem_we}, 32'd0);
      chk("rst_mid_b_rdata", intf.b_rdata, 32'd0);
      chk("rst_mid_bus", {intf.mem_addr, intf.mem_wdata}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      intf.a_req  = 1'b1;
      intf.a_we   = 1'b0;
      intf.a_addr = 11'h080;
      @(negedge clk);
      chk("rst_mid_idle_gnt", {31'd0, intf.a_gnt}, 32'd1);
      chk("rst_mid_no_ack", {31'd0, intf.b_ack}, 32'd0);
      tick();
      intf.a_req = 1'b0;
      @(negedge clk);
      chk("rst_mid_a_rd", {24'd0, intf.a_rdata}, 32'hD4);
      chk("rst_mid_bytes", {mem[11'h83], mem[11'h82], mem[11'h81],
                            mem[11'h80]}, 32'h0000C3D4);
      tick();
      chk("b_req_held", {31'd0, proto_err}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram6116_arbiter.md
# sram6116_arbiter

Shares the single-port 2K×8 6116 BRAM between two requesters:
- **Port A:** the native 8-bit emulated-system port.
- **Port B:** a 32-bit word port fed by the `to_bram` AXI4-Lite slave.

Port B word accesses are serialised into four byte cycles. Port A has priority, and a wait counter guarantees Port B forward progress. The block sits between the AXI slave logic and the BRAM primitive inside `top_6116`.

## Interface
Parameters:
- `ADDR_W`, 11, byte address width of the 6116 BRAM
- `MAX_WAIT`, 8, cycles Port B may be denied before it wins over Port A (1..255)

Ports (one clock; reset is asynchronous and active-high):
- `ACLK`  in  1  clock, all logic on rising edge
- `ARESET`  in  1  asynchronous active-high reset
- `a_req`  in  1  Port A access request
- `a_we`  in  1  Port A write
- `a_addr`  in  `ADDR_W`  Port A byte address
- `a_wdata`  in  8  Port A write data
- `a_gnt`  out  1  Port A access performed this cycle
- `a_rvalid`  out  1  Port A read data valid
- `a_rdata`  out  8  Port A read data
- `b_req`  in  1  Port B request, held until `b_ack`
- `b_we`  in  1  Port B write
- `b_addr`  in  `ADDR_W-2`  Port B word address
- `b_wdata`  in  32  Port B write data, lane i = bits [8i+7:8i]
- `b_wstrb`  in  4  Port B byte strobes
- `b_ack`  out  1  Port B transaction done (1-cycle pulse)
- `b_rdata`  out  32  Port B read word
- `mem_en`  out  1  BRAM enable
- `mem_we`  out  1  BRAM write enable
- `mem_addr`  out  `ADDR_W`  BRAM address
- `mem_wdata`  out  8  BRAM write data
- `mem_rdata`  in  8  BRAM read data, valid one cycle after `mem_en` with `mem_we`=0

## Operation
- **States:** IDLE, B_RUN, B_LAST, B_ACK.
- **IDLE arbitration:**
  - If `b_req` and (`!a_req` or `wait_cnt`==`MAX_WAIT`): latch B request, clear `wait_cnt`, go to B_RUN with lane=0. No memory access this cycle.
  - Else if `a_req`: `a_gnt`=1 combinationally and mem_* driven from A inputs in the same cycle. `wait_cnt` increments (saturating at `MAX_WAIT`) if `b_req`=1.
- **A access rules:**
  - Port A is served only in IDLE.
  - `a_gnt`=0 in every other state; Port A keeps `a_req` held.
- **B_RUN (4 cycles):**
  - Lane i: `mem_addr`={latched addr, i[1:0]}.
  - Write: `mem_en`=`mem_we`=`wstrb[i]`, `mem_wdata`=lane i. Unstrobed lanes still consume a cycle with `mem_en`=0.
  - Read: `mem_en`=1 on every lane.
  - lane==3 → B_LAST.
- **B_LAST:**
  - No memory access.
  - Read data for lane i is captured into `b_rdata`[8i+7:8i] the cycle after lane i is issued; lane 3 is captured at the end of B_LAST.
- **B_ACK:**
  - `b_ack`=1; go to IDLE.
  - `b_rdata` holds until the next B read completes; writes leave it unchanged.
- B transactions are atomic; Port A cannot interleave.
- `a_rvalid` pulses only for A reads, never for A writes.

## Timing
- **Port A latency:** `a_gnt` at cycle T; `a_rvalid`/`a_rdata` at T+1.
- **Port B latency:** accepted at IDLE cycle T; lanes issued at T+1..T+4; B_LAST at T+5; `b_ack` at T+6; IDLE at T+7 (7-cycle occupancy).
- **Port A during B:** a pending A request is served at T+7 at the earliest.
- **Starvation bound:** with A saturating, B starts no later than `MAX_WAIT` IDLE cycles after `b_req` rises.
- **Simultaneous A and B with `wait_cnt`<`MAX_WAIT`:** A wins.
- **Reset values:** state IDLE; all outputs 0, including `b_rdata`=0 and `wait_cnt`=0.
- **Reset mid-B:** already-written bytes stay written; no `b_ack` is produced.
- **`b_req` dropped before `b_ack`:** protocol violation; behaviour is undefined, and the bench asserts against it.

## Structure
- Package `sram6116_pkg`:
  - state enum
  - `LANES`=4
  - default `ADDR_W`=11
- One sub-module, `sram6116_starve_cnt`: the saturating wait counter with clear/inc and an `at_max` flag, parameterised by `MAX_WAIT`.
- Lane counter, capture register and FSM live in `sram6116_arbiter`.

## Test plan
- **A write then read:** A writes 0x5A to 0x123, then reads 0x123 → `a_gnt` each cycle; `a_rvalid`=1 with `a_rdata`=0x5A one cycle after the read grant.
- **B full write/readback:** B writes 0xDEAD0011 at word 0x10, strobe 0xF, then reads it → bytes 0x11,0x00,0xAD,0xDE at 0x40..0x43; `b_ack` 6 cycles after accept; `b_rdata`=0xDEAD0011.
- **Partial strobe:** preload word 0x10 with 0xBEEF0011; B writes 0x12345678 with strobe 0x5 → read returns 0xBE340078, and `mem_en`=0 on lanes 1 and 3.
- **Starvation:** `a_req` held every cycle, `b_req` raised at cycle 0 with `MAX_WAIT`=8 → exactly 8 A grants, then B accepted; no A grant until `b_ack`+1.
- **Simultaneous start:** `a_req` and `b_req` rise together with `wait_cnt`=0 → A granted first, B accepted next cycle.
- **Reset mid-B:** `ARESET` pulsed during lane 2 of a write of 0xA1B2C3D4 → lanes 0-1 (0xD4, 0xC3) written, lanes 2-3 untouched, no `b_ack`, all outputs 0, state IDLE.
